reg_file: RTL



---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_entry.sv | 26 ++
 rtl/reg_file.sv | 134 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types, defaults and the byte-strobe merge helper for reg_file.
package regfile_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned MAX_WIDTH     = 256;
  localparam int unsigned MAX_STRB      = MAX_WIDTH / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Replace only the bytes of old_v whose strobe bit is set; callers zero-extend.
  function automatic logic [MAX_WIDTH-1:0] strb_merge(
    input logic [MAX_WIDTH-1:0] old_v,
    input logic [MAX_WIDTH-1:0] new_v,
    input logic [MAX_STRB-1:0]  strb
  );
    logic [MAX_WIDTH-1:0] res;
    res = old_v;
    for (int unsigned i = 0; i < MAX_STRB; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_entry.sv
// One register-file word: byte-enabled write with a synchronous clear that wins over writes.
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic               clr,
  output logic [WIDTH-1:0]   q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (wr_en) begin
      q <= WIDTH'(strb_merge(MAX_WIDTH'(q), MAX_WIDTH'(wdata), MAX_STRB'(wstrb)));
    end
  end

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file: one byte-strobed write port, two registered read ports,
// and a one-entry-per-cycle bulk-clear sequencer. Optional same-edge write bypass: REGFILE_BYPASS_EN.
module reg_file
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]  raddr_a,
  output logic [WIDTH-1:0]   rdata_a,
  input  logic [ADDR_W-1:0]  raddr_b,
  output logic [WIDTH-1:0]   rdata_b,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               clr_done
);

  clr_state_e        state;
  logic [ADDR_W-1:0] cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  clr_sel;
  logic              wr_ok;
  logic              wr_hit;
  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;
  logic [WIDTH-1:0]  rd_a_nxt;
  logic [WIDTH-1:0]  rd_b_nxt;

  // Writes only land when idle and no clear is being requested on the same edge.
  always_comb begin
    wr_ok   = we && (state == IDLE) && !clr_req;
    wr_sel  = '0;
    clr_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_sel[i]  = wr_ok && (waddr == ADDR_W'(i));
      clr_sel[i] = (state == CLEAR) && (cnt == ADDR_W'(i));
    end
    wr_hit = |wr_sel;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    regfile_entry #(.WIDTH(WIDTH)) u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_sel[g]),
      .wdata (wdata),
      .wstrb (wstrb),
      .clr   (clr_sel[g]),
      .q     (mem[g])
    );
  end

  // Address decode for reads; addresses at or beyond DEPTH fall through to zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i)) rd_a = mem[i];
      if (raddr_b == ADDR_W'(i)) rd_b = mem[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_new;

  always_comb begin
    wr_old = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (waddr == ADDR_W'(i)) wr_old = mem[i];
    end
    wr_new = WIDTH'(strb_merge(MAX_WIDTH'(wr_old), MAX_WIDTH'(wdata), MAX_STRB'(wstrb)));
  end

  assign rd_a_nxt = (wr_hit && (waddr == raddr_a)) ? wr_new : rd_a;
  assign rd_b_nxt = (wr_hit && (waddr == raddr_b)) ? wr_new : rd_b;
`else
  assign rd_a_nxt = rd_a;
  assign rd_b_nxt = rd_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= rd_a_nxt;
      rdata_b <= rd_b_nxt;
    end
  end

  // Clear sequencer: one entry per edge, done pulses on the edge that clears the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  logic unused_wr_hit;
  assign unused_wr_hit = wr_hit;

endmodule
